// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Sequences one fully-connected layer of neurons:
//   FEED  : accept INPUT_NUM beats from upstream and broadcast each one to all
//           neurons as a one-cycle registered pulse.
//   WAIT  : collect each neuron's first outValid pulse into a capture buffer.
//           Gives up after TIMEOUT cycles and raises the sticky error flag.
//   DRAIN : stream the captured words downstream, neuron 0 first.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   inValid_i/inData_i/inReady_o  upstream valid/ready stream
//   neuronInput_o/ValidO          broadcast beat to every neuron
//   neuronOutValid_i/neuronOut_i  per-neuron result valid and packed results
//   outValid_o/outData_o/outReady_i downstream valid/ready stream
//   busy_o                        a vector is in progress
//   error_o                       sticky fault flag (timeout or stray result)
// -----------------------------------------------------------------------------
module layer_sequencer #(
    parameter int INPUT_NUM  = 784,
    parameter int NEURON_NUM = 30,
    parameter int DATA_WIDTH = 16,
    parameter int TIMEOUT    = 1024
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             inValid_i,
    input  logic [DATA_WIDTH-1:0]            inData_i,
    output logic                             inReady_o,
    output logic [DATA_WIDTH-1:0]            neuronInput_o,
    output logic                             neuronInputValid_o,
    input  logic [NEURON_NUM-1:0]            neuronOutValid_i,
    input  logic [NEURON_NUM*DATA_WIDTH-1:0] neuronOut_i,
    output logic                             outValid_o,
    output logic [DATA_WIDTH-1:0]            outData_o,
    input  logic                             outReady_i,
    output logic                             busy_o,
    output logic                             error_o
);

    localparam int FEED_W  = $clog2(INPUT_NUM + 1);
    localparam int IDX_W   = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;
    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    localparam logic [FEED_W-1:0]  FEED_LAST  = FEED_W'(INPUT_NUM - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NEURON_NUM - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_FEED  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [FEED_W-1:0]       feed_cnt_q,  feed_cnt_d;
    logic [IDX_W-1:0]        drain_idx_q, drain_idx_d;
    logic [TIMER_W-1:0]      timer_q,     timer_d;
    logic [NEURON_NUM-1:0]   done_q,      done_d;
    logic [DATA_WIDTH-1:0]   cap_q [NEURON_NUM];
    logic [DATA_WIDTH-1:0]   cap_d [NEURON_NUM];
    logic [DATA_WIDTH-1:0]   nin_data_q,  nin_data_d;
    logic                    nin_valid_q, nin_valid_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q,  out_data_d;
    logic                    error_q,     error_d;

    logic [DATA_WIDTH-1:0]   slice [NEURON_NUM];
    logic [NEURON_NUM-1:0]   cap_en;
    logic                    accept;
    logic                    all_done;
    logic [IDX_W-1:0]        drain_next_idx;

    // Unpack the flat neuron result bus into one word per neuron.
    generate
        for (genvar gi = 0; gi < NEURON_NUM; gi++) begin : g_slice
            assign slice[gi] = neuronOut_i[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Only the first pulse of each neuron per vector is captured.
    assign cap_en         = neuronOutValid_i & ~done_q;
    // Neurons already done plus those reporting now cover the whole layer.
    assign all_done       = &(done_q | neuronOutValid_i);
    assign inReady_o      = (state_q == ST_FEED) & ~rst_i;
    assign accept         = inValid_i & inReady_o;
    assign drain_next_idx = drain_idx_q + IDX_W'(1);

    assign neuronInput_o      = nin_data_q;
    assign neuronInputValid_o = nin_valid_q;
    assign outValid_o         = out_valid_q;
    assign outData_o          = out_data_q;
    assign error_o            = error_q;
    assign busy_o             = (state_q != ST_FEED) | (feed_cnt_q != '0);

    always_comb begin
        state_d     = state_q;
        feed_cnt_d  = feed_cnt_q;
        drain_idx_d = drain_idx_q;
        timer_d     = timer_q;
        done_d      = done_q;
        cap_d       = cap_q;
        nin_data_d  = nin_data_q;
        nin_valid_d = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        error_d     = error_q;

        case (state_q)
            ST_FEED: begin
                if (accept) begin
                    nin_data_d  = inData_i;
                    nin_valid_d = 1'b1;
                    if (feed_cnt_q == FEED_LAST) begin
                        feed_cnt_d = '0;
                        state_d    = ST_WAIT;
                    end else begin
                        feed_cnt_d = feed_cnt_q + FEED_W'(1);
                    end
                end
                if (|neuronOutValid_i) begin
                    error_d = 1'b1;
                end
            end

            ST_WAIT: begin
                for (int k = 0; k < NEURON_NUM; k++) begin
                    if (cap_en[k]) begin
                        cap_d[k]  = slice[k];
                        done_d[k] = 1'b1;
                    end
                end
                // Completion is checked before expiry so a last-cycle
                // completion still drains without an error.
                if (all_done) begin
                    state_d     = ST_DRAIN;
                    drain_idx_d = '0;
                    done_d      = '0;
                    timer_d     = '0;
                    out_valid_d = 1'b1;
                    // Neuron 0 may be captured in this very cycle.
                    out_data_d  = cap_d[0];
                end else if (timer_q == TIMER_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_FEED;
                    done_d  = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            ST_DRAIN: begin
                if (out_valid_q && outReady_i) begin
                    if (drain_idx_q == IDX_LAST) begin
                        out_valid_d = 1'b0;
                        drain_idx_d = '0;
                        state_d     = ST_FEED;
                    end else begin
                        drain_idx_d = drain_next_idx;
                        out_data_d  = cap_q[drain_next_idx];
                    end
                end
                if (|neuronOutValid_i) begin
                    error_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_FEED;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_FEED;
            feed_cnt_q  <= '0;
            drain_idx_q <= '0;
            timer_q     <= '0;
            done_q      <= '0;
            for (int k = 0; k < NEURON_NUM; k++) begin
                cap_q[k] <= '0;
            end
            nin_data_q  <= '0;
            nin_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            feed_cnt_q  <= feed_cnt_d;
            drain_idx_q <= drain_idx_d;
            timer_q     <= timer_d;
            done_q      <= done_d;
            cap_q       <= cap_d;
            nin_data_q  <= nin_data_d;
            nin_valid_q <= nin_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            error_q     <= error_d;
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

    localparam int IN = 3;
    localparam int NN = 2;
    localparam int DW = 16;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_ready;
    logic [DW-1:0]     nin;
    logic              nin_valid;
    logic [NN-1:0]     n_valid = '0;
    logic [NN*DW-1:0]  n_out = '0;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              err;

    int vectors_applied = 0;
    int miscompares     = 0;

    logic [DW-1:0] vec     [IN];
    logic [DW-1:0] exp_out [NN];

    layer_sequencer #(
        .INPUT_NUM (IN),
        .NEURON_NUM(NN),
        .DATA_WIDTH(DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .inValid_i         (in_valid),
        .inData_i          (in_data),
        .inReady_o         (in_ready),
        .neuronInput_o     (nin),
        .neuronInputValid_o(nin_valid),
        .neuronOutValid_i  (n_valid),
        .neuronOut_i       (n_out),
        .outValid_o        (out_valid),
        .outData_o         (out_data),
        .outReady_i        (out_ready),
        .busy_o            (busy),
        .error_o           (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors_applied++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present IN beats with up to gap_max idle cycles before each; every
    // accept must produce a pulse carrying that beat on the next cycle.
    task automatic feed_vec(input int gap_max);
        for (int i = 0; i < IN; i++) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = vec[i];
            chk("feed_ready", {31'b0, in_ready}, 32'd1);
            tick();
            chk("nin_valid", {31'b0, nin_valid}, 32'd1);
            chk("nin_data", {16'b0, nin}, {16'b0, vec[i]});
        end
        in_valid = 1'b0;
        chk("wait_ready", {31'b0, in_ready}, 32'd0);
        chk("wait_busy", {31'b0, busy}, 32'd1);
        $display("feed vector %h %h %h", vec[0], vec[1], vec[2]);
    endtask

    // Drain NN beats expecting exp_out in order, optionally stalling.
    task automatic drain_expect(input int stall_first, input bit rnd);
        int stall;
        for (int i = 0; i < NN; i++) begin
            stall = rnd ? int'($urandom_range(0, 2)) : ((i == 0) ? stall_first : 0);
            out_ready = 1'b0;
            repeat (stall) begin
                tick();
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_data", {16'b0, out_data}, {16'b0, exp_out[i]});
            end
            chk("drain_valid", {31'b0, out_valid}, 32'd1);
            chk("drain_data", {16'b0, out_data}, {16'b0, exp_out[i]});
            chk("drain_ready", {31'b0, in_ready}, 32'd0);
            $display("drain beat %0d data %h", i, out_data);
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
        chk("drain_end_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_end_ready", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic rand_vec();
        for (int i = 0; i < IN; i++) vec[i] = DW'($urandom);
    endtask

    // Both neurons pulse together; expect DRAIN on the next cycle.
    task automatic both_pulse(input logic [DW-1:0] a, input logic [DW-1:0] b);
        n_valid = 2'b11;
        n_out   = {b, a};
        tick();
        n_valid = '0;
        exp_out[0] = a;
        exp_out[1] = b;
    endtask

    initial begin
        int t_first [NN];
        int t_rep   [NN];
        logic [DW-1:0] v_first [NN];
        int c;
        int firsts;

        // ---------------- reset and idle ----------------
        tick();
        chk("rst_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_nin_valid", {31'b0, nin_valid}, 32'd0);
        chk("rst_nin", {16'b0, nin}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", {16'b0, out_data}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("rst2_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", {31'b0, in_ready}, 32'd1);
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_out_valid", {31'b0, out_valid}, 32'd0);

        // ---------------- feed, capture, drain ----------------
        vec[0] = 16'h0001; vec[1] = 16'h0002; vec[2] = 16'h0003;
        feed_vec(0);
        tick();
        chk("hold_nin_valid", {31'b0, nin_valid}, 32'd0);
        chk("hold_nin", {16'b0, nin}, 32'h0003);
        n_valid = 2'b10;
        n_out   = {16'h00AA, 16'h1234};
        tick();
        n_valid = '0;
        chk("partial_no_drain", {31'b0, out_valid}, 32'd0);
        tick();
        chk("partial_no_drain2", {31'b0, out_valid}, 32'd0);
        n_valid = 2'b01;
        n_out   = {16'h9999, 16'h0055};
        tick();
        n_valid = '0;
        exp_out[0] = 16'h0055;
        exp_out[1] = 16'h00AA;
        drain_expect(3, 1'b0);
        chk("cap_err", {31'b0, err}, 32'd0);

        // ---------------- simultaneous ----------------
        rand_vec();
        feed_vec(0);
        both_pulse(DW'($urandom), DW'($urandom));
        drain_expect(0, 1'b1);

        // ---------------- repeat pulse ----------------
        rand_vec();
        feed_vec(1);
        exp_out[0] = DW'($urandom);
        exp_out[1] = DW'($urandom);
        n_valid = 2'b01;
        n_out   = {16'h0000, exp_out[0]};
        tick();
        n_valid = 2'b01;
        n_out   = {16'h0000, 16'h1111};
        tick();
        chk("repeat_no_drain", {31'b0, out_valid}, 32'd0);
        n_valid = 2'b10;
        n_out   = {exp_out[1], 16'h2222};
        tick();
        n_valid = '0;
        drain_expect(0, 1'b1);
        chk("repeat_err", {31'b0, err}, 32'd0);

        // ---------------- randomized vectors ----------------
        for (int v = 0; v < 20; v++) begin
            rand_vec();
            feed_vec(2);
            for (int k = 0; k < NN; k++) begin
                t_first[k] = int'($urandom_range(0, 8));
                t_rep[k]   = ($urandom_range(0, 1) == 1) ? t_first[k] + 1 + int'($urandom_range(0, 3)) : -1;
                v_first[k] = DW'($urandom);
            end
            c = 0;
            firsts = 0;
            while (firsts < NN && c < 20) begin
                for (int k = 0; k < NN; k++) begin
                    n_valid[k] = 1'b0;
                    n_out[k*DW +: DW] = DW'($urandom);
                    if (t_first[k] == c) begin
                        n_valid[k] = 1'b1;
                        n_out[k*DW +: DW] = v_first[k];
                        firsts++;
                    end else if (t_rep[k] == c) begin
                        n_valid[k] = 1'b1;
                    end
                end
                tick();
                c++;
            end
            n_valid = '0;
            for (int k = 0; k < NN; k++) exp_out[k] = v_first[k];
            drain_expect(0, 1'b1);
        end
        chk("random_err", {31'b0, err}, 32'd0);

        // ---------------- timeout ----------------
        rand_vec();
        feed_vec(0);
        n_valid = 2'b01;
        n_out   = {16'h0000, 16'h7777};
        tick();
        n_valid = '0;
        for (int i = 0; i < TO - 2; i++) begin
            tick();
            chk("to_pending_err", {31'b0, err}, 32'd0);
            chk("to_pending_ready", {31'b0, in_ready}, 32'd0);
            chk("to_no_out", {31'b0, out_valid}, 32'd0);
        end
        tick();
        chk("to_err", {31'b0, err}, 32'd1);
        chk("to_ready", {31'b0, in_ready}, 32'd1);
        chk("to_no_out_end", {31'b0, out_valid}, 32'd0);
        rand_vec();
        feed_vec(0);
        both_pulse(DW'($urandom), DW'($urandom));
        drain_expect(0, 1'b1);
        chk("to_err_sticky", {31'b0, err}, 32'd1);

        // ---------------- reset mid-operation ----------------
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = DW'(16'h0100 + i);
            tick();
            chk("mid_nin_valid", {31'b0, nin_valid}, 32'd1);
        end
        in_data = 16'h0102;
        rst = 1'b1;
        tick();
        chk("mid_rst_nin_valid", {31'b0, nin_valid}, 32'd0);
        chk("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        chk("mid_rst_err", {31'b0, err}, 32'd0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("mid_post_nin_valid", {31'b0, nin_valid}, 32'd0);
        chk("mid_post_out_valid", {31'b0, out_valid}, 32'd0);
        rand_vec();
        feed_vec(0);
        both_pulse(DW'($urandom), DW'($urandom));
        drain_expect(0, 1'b0);

        // ---------------- stray neuron pulse in FEED ----------------
        n_valid = 2'b01;
        tick();
        n_valid = '0;
        chk("stray_err", {31'b0, err}, 32'd1);
        chk("stray_ready", {31'b0, in_ready}, 32'd1);
        chk("stray_out_valid", {31'b0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
